// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the exhaustive truth-table checker.
package truth_table_pkg;

    localparam int N_IN_DEFAULT          = 3;
    localparam int SETTLE_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } tt_state_e;

endpackage

// File: rtl/truth_table_checker_if.sv
// Control/stimulus/response bundle between a test driver and the checker.
interface truth_table_checker_if
    import truth_table_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) ();

    logic                 start;
    logic [2**N_IN-1:0]   exp_table;
    logic                 dut_f;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail_idx;

    modport master (
        output start, exp_table, dut_f,
        input  vec_out, busy, done, pass, err_count, first_fail_idx
    );

    modport slave (
        input  start, exp_table, dut_f,
        output vec_out, busy, done, pass, err_count, first_fail_idx
    );

endinterface

// File: rtl/tt_settle_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module tt_settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector, waits for the DUT to settle, and scores its
// response against a table captured at start.
module truth_table_checker
    import truth_table_pkg::*;
#(
    parameter int N_IN          = N_IN_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);

    localparam int NV = 2**N_IN;
    localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

    tt_state_e           state, state_nxt;
    logic [NV-1:0]       exp_q;
    logic [N_IN-1:0]     vec_q;
    logic [N_IN:0]       err_q, err_nxt;
    logic [N_IN-1:0]     ffi_q;
    logic                pass_q;
    logic                settle_tc;
    logic                last_vec;
    logic                mismatch;

    // Loaded during APPLY so SETTLE sees SETTLE_CYCLES-1 .. 0.
    tt_settle_counter #(.W(4)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == APPLY),
        .load_val (4'(SETTLE_CYCLES - 1)),
        .en       (state == SETTLE),
        .tc       (settle_tc)
    );

    assign last_vec = (vec_q == {N_IN{1'b1}});
    assign mismatch = (state == SAMPLE) && (bus.dut_f != exp_q[vec_q]);

    always_comb begin
        err_nxt = err_q;
        if (mismatch && err_q != ERR_MAX)
            err_nxt = err_q + (N_IN+1)'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (settle_tc) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? FINISH : APPLY;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            exp_q  <= '0;
            vec_q  <= '0;
            err_q  <= '0;
            ffi_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                exp_q  <= bus.exp_table;
                vec_q  <= '0;
                err_q  <= '0;
                ffi_q  <= '0;
                pass_q <= 1'b0;
            end else if (state == SAMPLE) begin
                err_q <= err_nxt;
                if (mismatch && err_q == '0)
                    ffi_q <= vec_q;
                // pass is published with done, so it must include this sample
                if (last_vec)
                    pass_q <= (err_nxt == '0);
                else
                    vec_q <= vec_q + N_IN'(1);
            end
        end
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
    assign bus.done           = (state == FINISH);
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: majority-function DUT model, stuck-at-0 DUT, restart
// attempts, table changes, mid-run reset and held start.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic dut_mode;   // 0: majority DUT, 1: output stuck at 0
    int   n_chk = 0;
    int   n_err = 0;

    truth_table_checker_if #(.N_IN(3)) bus ();

    truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic maj;
    assign maj = (bus.vec_out[2] & bus.vec_out[1]) |
                 (bus.vec_out[2] & bus.vec_out[0]) |
                 (bus.vec_out[1] & bus.vec_out[0]);
    assign bus.dut_f = dut_mode ? 1'b0 : maj;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // flags[0]: poke start at m=5 and m=20; flags[1]: zero the table at m=10
    task automatic run(input string nm, input logic [7:0] tbl, input logic dmode,
                       input logic [1:0] flags, input int exp_err,
                       input int exp_ffi, input int exp_pass);
        int bad;
        bus.exp_table = tbl;
        dut_mode      = dmode;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_clr"}, int'(bus.err_count), 0);
        bad = 0;
        for (int m = 0; m < 32; m++) begin
            if (int'(bus.vec_out) != m / 4 || !bus.busy || bus.done) bad++;
            bus.start = flags[0] && (m == 5 || m == 20);
            if (flags[1] && m == 10) bus.exp_table = 8'h00;
            @(negedge clk);
        end
        chk({nm, "_seq"}, bad, 0);
        chk({nm, "_done"}, int'(bus.done), 1);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_pass"}, int'(bus.pass), exp_pass);
        chk({nm, "_err"}, int'(bus.err_count), exp_err);
        if (exp_err != 0) chk({nm, "_ffi"}, int'(bus.first_fail_idx), exp_ffi);
        @(negedge clk);
        chk({nm, "_done1"}, int'(bus.done), 0);
        chk({nm, "_hold"}, int'(bus.pass), exp_pass);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.exp_table = 8'h00;
        dut_mode      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec",  int'(bus.vec_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pass", int'(bus.pass), 0);
        chk("rst_err",  int'(bus.err_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("maj",    8'hE8, 1'b0, 2'b00, 0, 0, 1);
        run("stuck0", 8'hE8, 1'b1, 2'b00, 4, 3, 0);
        run("poke",   8'hE8, 1'b0, 2'b01, 0, 0, 1);
        run("tblchg", 8'hE8, 1'b0, 2'b10, 0, 0, 1);

        // Reset while vector 5 is applied; start asserted alongside is ignored.
        bus.exp_table = 8'hE8;
        dut_mode      = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_vec", int'(bus.vec_out), 5);
        chk("mid_err", int'(bus.err_count), 1);
        chk("mid_ffi", int'(bus.first_fail_idx), 3);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        chk("mrst_vec",  int'(bus.vec_out), 0);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_done", int'(bus.done), 0);
        chk("mrst_err",  int'(bus.err_count), 0);
        chk("mrst_ffi",  int'(bus.first_fail_idx), 0);
        chk("mrst_pass", int'(bus.pass), 0);
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_vec",  int'(bus.vec_out), 0);

        // Start held high: stuck run, then a majority run retriggered.
        bus.exp_table = 8'hE8;
        dut_mode      = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        repeat (32) @(negedge clk);
        chk("hold_done", int'(bus.done), 1);
        chk("hold_err",  int'(bus.err_count), 4);
        dut_mode = 1'b0;
        @(negedge clk);
        chk("hold_idle", int'(bus.busy), 0);
        chk("hold_keep", int'(bus.err_count), 4);
        @(negedge clk);
        chk("re_busy", int'(bus.busy), 1);
        chk("re_clr",  int'(bus.err_count), 0);
        chk("re_vec",  int'(bus.vec_out), 0);
        bus.start = 1'b0;
        repeat (32) @(negedge clk);
        chk("re_done", int'(bus.done), 1);
        chk("re_pass", int'(bus.pass), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N_IN, default 3: number of DUT inputs; the table has 2**N_IN vectors.
REQ-002 Parameter SETTLE_CYCLES, default 2: clock cycles between applying a vector and sampling the response (range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request a full exhaustive run; sampled only in IDLE.
REQ-006 exp_table  input  2**N_IN  expected DUT output; bit i = expected response to vector i.
REQ-007 dut_f  input  1  DUT response under test.
REQ-008 vec_out  output  N_IN  applied vector; MSB drives the first DUT input (x), LSB the last (y).
REQ-009 busy  output  1  high from APPLY of vector 0 through SAMPLE of the last vector.
REQ-010 done  output  1  single-cycle pulse at run completion.
REQ-011 pass  output  1  high when the last completed run had zero mismatches.
REQ-012 err_count  output  N_IN+1  number of mismatching vectors in the current or last run.
REQ-013 first_fail_idx  output  N_IN  index of the first mismatching vector; valid only when err_count != 0.

Function
REQ-014 FSM states: IDLE, APPLY, SETTLE, SAMPLE, FINISH.
REQ-015 IDLE, start=1 -> APPLY. In the same edge: capture exp_table into an internal register; clear err_count, pass and first_fail_idx; set vec_out=0.
REQ-016 APPLY lasts 1 cycle -> SETTLE. SETTLE lasts exactly SETTLE_CYCLES cycles -> SAMPLE. SAMPLE lasts 1 cycle.
REQ-017 SAMPLE compares dut_f with the captured exp_table[vec_out]. On mismatch: increment err_count; if err_count was 0, load first_fail_idx=vec_out.
REQ-018 SAMPLE with vec_out < 2**N_IN-1 -> APPLY with vec_out+1. SAMPLE with vec_out = 2**N_IN-1 -> FINISH; vec_out holds its value.
REQ-019 FINISH lasts 1 cycle: done=1, pass=(err_count==0) -> IDLE.
REQ-020 A run takes exactly 2**N_IN*(SETTLE_CYCLES+2) cycles from the start-accept edge to the done cycle (32 cycles at defaults).
REQ-021 start is ignored while busy or in FINISH. A start held high re-triggers on the IDLE cycle after done.
REQ-022 exp_table changes after capture do not affect the run in progress.
REQ-023 vec_out is stable for the whole APPLY..SAMPLE window of each vector.
REQ-024 err_count saturates at 2**N_IN and cannot wrap.
REQ-025 pass, err_count and first_fail_idx hold after done until the next accepted start.

Reset
REQ-026 When rst_n=0 at a rising edge, in any state including mid-run, the next state is IDLE with vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, and the captured table cleared.
REQ-027 A start asserted in the same cycle as rst_n=0 is ignored.

Structure
REQ-028 Package truth_table_pkg holds:
- the FSM state enum typedef;
- default constants for N_IN and SETTLE_CYCLES.
REQ-029 Sub-module tt_settle_counter: a loadable down-counter with a terminal-count flag. It times SETTLE and is instantiated once.

Verification
REQ-030 Model a majority-function DUT, exp_table=8'hE8, pulse start -> vec_out steps 0..7, done pulses 32 cycles after start accept, pass=1, err_count=0.
REQ-031 Tie dut_f=0, exp_table=8'hE8 -> err_count=4, first_fail_idx=3, pass=0.
REQ-032 Apply start again at cycles 5 and 20 of a run -> no restart, and done still occurs at cycle 32.
REQ-033 Assert rst_n=0 for one cycle while vec_out=5 -> all outputs at reset values on the next cycle, and the FSM stays IDLE until a new start.
REQ-034 Change exp_table from 8'hE8 to 8'h00 mid-run with a correct majority DUT -> pass=1.
REQ-035 Hold start high continuously -> second run begins on the IDLE cycle after done, and err_count clears at the accept edge.
